// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types and sizing: 4 entries per warp, 2-bit ScbID, 5-bit RegID.
package scoreboard_pkg;

  localparam int unsigned NUM_ENTRIES = 4;
  localparam int unsigned SCBID_W     = 2;
  localparam int unsigned REGID_W     = 5;

  typedef logic [SCBID_W-1:0] scbid_t;
  typedef logic [REGID_W-1:0] regid_t;

  typedef struct packed {
    logic   valid;
    regid_t dst;
    logic   wb_pend;
    logic   incomplete;
  } entry_t;

  // Lowest-index invalid entry; 0 when every entry is valid.
  function automatic scbid_t first_free(input logic [NUM_ENTRIES-1:0] valid);
    scbid_t idx;
    idx = '0;
    for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
      if (!valid[k]) idx = scbid_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scoreboard_warp.sv
// Four-entry scoreboard for one warp: allocation, writeback/replay clears and hazard detection.
module scoreboard_warp
  import scoreboard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   alloc,
  input  regid_t src1,
  input  regid_t src2,
  input  regid_t dst,
  input  logic   src1_valid,
  input  logic   src2_valid,
  input  logic   dst_valid,
  input  logic   replayable,
  input  logic   replay_complete,
  input  scbid_t replay_scbid,
  input  logic   replay_sw,
  input  logic   clear,
  input  scbid_t clear_scbid,
  output logic   full,
  output logic   empty,
  output logic   dependent,
  output scbid_t scbid
);

  entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
  logic   [NUM_ENTRIES-1:0] valid_vec;
  logic   [NUM_ENTRIES-1:0] clr_hit;
  logic   [NUM_ENTRIES-1:0] rc_hit;
  logic                     alloc_en;

  always_comb begin
    valid_vec = '0;
    clr_hit   = '0;
    rc_hit    = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      valid_vec[k] = ent_q[k].valid;
      clr_hit[k]   = clear && (clear_scbid == scbid_t'(k));
      rc_hit[k]    = replay_complete && (replay_scbid == scbid_t'(k));
    end
  end

  assign full  = &valid_vec;
  assign empty = ~|valid_vec;
  assign scbid = first_free(valid_vec);

  // An instruction with neither a destination nor a replay needs no tracking.
  assign alloc_en = alloc && !full && (dst_valid || replayable);

  always_comb begin
    dependent = 1'b0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (ent_q[k].valid && ent_q[k].wb_pend &&
          ((src1_valid && (ent_q[k].dst == src1)) ||
           (src2_valid && (ent_q[k].dst == src2)) ||
           (dst_valid  && (ent_q[k].dst == dst)))) begin
        dependent = 1'b1;
      end
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (alloc_en && (scbid == scbid_t'(k))) begin
        ent_d[k].valid      = 1'b1;
        ent_d[k].dst        = dst;
        ent_d[k].wb_pend    = dst_valid;
        ent_d[k].incomplete = replayable;
      end else if (ent_q[k].valid) begin
        if (clr_hit[k]) ent_d[k].wb_pend    = 1'b0;
        if (rc_hit[k])  ent_d[k].incomplete = 1'b0;
        // Free once nothing is outstanding; an SW completion retires the entry outright.
        if ((rc_hit[k] && replay_sw) || (!ent_d[k].wb_pend && !ent_d[k].incomplete)) begin
          ent_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ent_q <= '0;
    else     ent_q <= ent_d;
  end

  a_alloc_full : assert property (@(posedge clk) disable iff (rst) !(alloc && full))
    else $warning("scoreboard_warp: RP_grt on a full warp ignored");
  a_clear_valid : assert property (@(posedge clk) disable iff (rst)
                                   clear |-> valid_vec[clear_scbid])
    else $warning("scoreboard_warp: WB clear to invalid entry ignored");
  a_replay_valid : assert property (@(posedge clk) disable iff (rst)
                                    replay_complete |-> valid_vec[replay_scbid])
    else $warning("scoreboard_warp: replay completion to invalid entry ignored");

endmodule

// File: rtl/scoreboard.sv
// Per-warp register scoreboard: splits the flattened IBuffer buses and decodes the WB clear.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned NUM_WARPS    = 8,
  parameter int unsigned LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WARPS-1:0]           RP_grt_IB_Scb,
  input  logic [REGID_W*NUM_WARPS-1:0]   src1_flattened_IB_Scb,
  input  logic [REGID_W*NUM_WARPS-1:0]   src2_flattened_IB_Scb,
  input  logic [REGID_W*NUM_WARPS-1:0]   dst_flattened_IB_Scb,
  input  logic [NUM_WARPS-1:0]           src1_valid_IB_Scb,
  input  logic [NUM_WARPS-1:0]           src2_valid_IB_Scb,
  input  logic [NUM_WARPS-1:0]           dst_valid_IB_Scb,
  input  logic [NUM_WARPS-1:0]           replayable_IB_Scb,
  input  logic [NUM_WARPS-1:0]           replay_complete_IB_Scb,
  input  logic [SCBID_W*NUM_WARPS-1:0]   replay_complete_ScbID_flattened_IB_Scb,
  input  logic [NUM_WARPS-1:0]           replay_SW_LWbar_IB_Scb,
  input  logic                           Clear_Valid_WB_Scb,
  input  logic [LOGNUM_WARPS-1:0]        Clear_WarpID_WB_Scb,
  input  logic [SCBID_W-1:0]             Clear_ScbID_WB_Scb,
  output logic [NUM_WARPS-1:0]           full_Scb_IB,
  output logic [NUM_WARPS-1:0]           empty_Scb_IB,
  output logic [NUM_WARPS-1:0]           dependent_Scb_IB,
  output logic [SCBID_W*NUM_WARPS-1:0]   ScbID_flattened_Scb_IB
);

  logic [NUM_WARPS-1:0] clear_vec;

  always_comb begin
    clear_vec = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      clear_vec[i] = Clear_Valid_WB_Scb && (Clear_WarpID_WB_Scb == LOGNUM_WARPS'(i));
    end
  end

  for (genvar i = 0; i < NUM_WARPS; i++) begin : g_warp
    scoreboard_warp u_warp (
      .clk             (clk),
      .rst             (rst),
      .alloc           (RP_grt_IB_Scb[i]),
      .src1            (src1_flattened_IB_Scb[i*REGID_W +: REGID_W]),
      .src2            (src2_flattened_IB_Scb[i*REGID_W +: REGID_W]),
      .dst             (dst_flattened_IB_Scb[i*REGID_W +: REGID_W]),
      .src1_valid      (src1_valid_IB_Scb[i]),
      .src2_valid      (src2_valid_IB_Scb[i]),
      .dst_valid       (dst_valid_IB_Scb[i]),
      .replayable      (replayable_IB_Scb[i]),
      .replay_complete (replay_complete_IB_Scb[i]),
      .replay_scbid    (replay_complete_ScbID_flattened_IB_Scb[i*SCBID_W +: SCBID_W]),
      .replay_sw       (replay_SW_LWbar_IB_Scb[i]),
      .clear           (clear_vec[i]),
      .clear_scbid     (Clear_ScbID_WB_Scb),
      .full            (full_Scb_IB[i]),
      .empty           (empty_Scb_IB[i]),
      .dependent       (dependent_Scb_IB[i]),
      .scbid           (ScbID_flattened_Scb_IB[i*SCBID_W +: SCBID_W])
    );
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard with an in-bench entry model checked every cycle.
module tb_scoreboard;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   rp_grt, s1v, s2v, dv, rpl, rc, rsw;
  logic [5*W-1:0] src1, src2, dst;
  logic [2*W-1:0] rc_id;
  logic           clr_v;
  logic [2:0]     clr_w;
  logic [1:0]     clr_id;
  logic [W-1:0]   full, empty, dep;
  logic [2*W-1:0] scbid;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  scoreboard #(.NUM_WARPS(W)) dut (
    .clk                                    (clk),
    .rst                                    (rst),
    .RP_grt_IB_Scb                          (rp_grt),
    .src1_flattened_IB_Scb                  (src1),
    .src2_flattened_IB_Scb                  (src2),
    .dst_flattened_IB_Scb                   (dst),
    .src1_valid_IB_Scb                      (s1v),
    .src2_valid_IB_Scb                      (s2v),
    .dst_valid_IB_Scb                       (dv),
    .replayable_IB_Scb                      (rpl),
    .replay_complete_IB_Scb                 (rc),
    .replay_complete_ScbID_flattened_IB_Scb (rc_id),
    .replay_SW_LWbar_IB_Scb                 (rsw),
    .Clear_Valid_WB_Scb                     (clr_v),
    .Clear_WarpID_WB_Scb                    (clr_w),
    .Clear_ScbID_WB_Scb                     (clr_id),
    .full_Scb_IB                            (full),
    .empty_Scb_IB                           (empty),
    .dependent_Scb_IB                       (dep),
    .ScbID_flattened_Scb_IB                 (scbid)
  );

  // Model: what each warp's in-flight instructions are still waiting on.
  bit         m_valid[W][4];
  bit         m_wb[W][4];
  bit         m_inc[W][4];
  logic [4:0] m_dst[W][4];

  function automatic bit m_full(int w);
    for (int k = 0; k < 4; k++) if (!m_valid[w][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_empty(int w);
    for (int k = 0; k < 4; k++) if (m_valid[w][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_free(int w);
    for (int k = 0; k < 4; k++) if (!m_valid[w][k]) return k;
    return 0;
  endfunction

  function automatic bit m_dep(int w);
    for (int k = 0; k < 4; k++) begin
      if (m_valid[w][k] && m_wb[w][k]) begin
        if (s1v[w] && m_dst[w][k] == src1[w*5 +: 5]) return 1'b1;
        if (s2v[w] && m_dst[w][k] == src2[w*5 +: 5]) return 1'b1;
        if (dv[w]  && m_dst[w][k] == dst[w*5 +: 5])  return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < W; w++)
        for (int k = 0; k < 4; k++) begin
          m_valid[w][k] = 1'b0; m_wb[w][k] = 1'b0; m_inc[w][k] = 1'b0; m_dst[w][k] = '0;
        end
    end else begin
      for (int w = 0; w < W; w++) begin
        int  f;
        int  k;
        bit  was_full;
        f        = m_free(w);
        was_full = m_full(w);
        if (clr_v && int'(clr_w) == w && m_valid[w][clr_id]) m_wb[w][clr_id] = 1'b0;
        if (rc[w]) begin
          k = int'(rc_id[w*2 +: 2]);
          if (m_valid[w][k]) begin
            m_inc[w][k] = 1'b0;
            if (rsw[w]) m_valid[w][k] = 1'b0;
          end
        end
        if (rp_grt[w] && !was_full && (dv[w] || rpl[w])) begin
          m_valid[w][f] = 1'b1;
          m_dst[w][f]   = dst[w*5 +: 5];
          m_wb[w][f]    = dv[w];
          m_inc[w][f]   = rpl[w];
        end
        for (int j = 0; j < 4; j++)
          if (m_valid[w][j] && !m_wb[w][j] && !m_inc[w][j]) m_valid[w][j] = 1'b0;
      end
    end
  end

  // Per-cycle compare; ScbID is don't-care while a warp is full.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int w = 0; w < W; w++) begin
        logic [4:0] exp_v, act_v;
        exp_v = {m_full(w), m_empty(w), m_dep(w), m_full(w) ? 2'd0 : 2'(m_free(w))};
        act_v = {full[w], empty[w], dep[w], m_full(w) ? 2'd0 : scbid[w*2 +: 2]};
        tests++;
        if (act_v !== exp_v) begin
          fails++;
          $display("FAIL model_w%0d @%0t: got full/empty/dep/id=%b want %b", w, $time, act_v,
                   exp_v);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    rp_grt = '0; s1v = '0; s2v = '0; dv = '0; rpl = '0; rc = '0; rsw = '0;
    src1 = '0; src2 = '0; dst = '0; rc_id = '0; clr_v = 1'b0; clr_w = '0; clr_id = '0;
  endtask

  task automatic alloc(input int w, input logic [4:0] d, input logic dvl, input logic rp);
    rp_grt[w] = 1'b1; dst[w*5 +: 5] = d; dv[w] = dvl; rpl[w] = rp;
  endtask

  task automatic wbclr(input int w, input logic [1:0] id);
    clr_v = 1'b1; clr_w = 3'(w); clr_id = id;
  endtask

  task automatic rcomp(input int w, input logic [1:0] id, input logic sw);
    rc[w] = 1'b1; rc_id[w*2 +: 2] = id; rsw[w] = sw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    smp();
    check("rst_empty", 32'(empty), 32'hFF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_scbid", 32'(scbid), 32'h0);
    check("rst_dep", 32'(dep), 32'h0);
    tick();

    // Fill warp 3 with R1..R4, then hazard queries against it
    for (int i = 0; i < 4; i++) begin
      idle(); alloc(3, 5'(i + 1), 1'b1, 1'b0);
      smp(); check("fill_scbid", 32'(scbid[7:6]), 32'(i));
      tick();
    end
    idle(); src1[15 +: 5] = 5'd3; s1v[3] = 1'b1;
    smp();
    check("fill_full", 32'(full[3]), 32'h1);
    check("fill_empty", 32'(empty[3]), 32'h0);
    check("raw_src1", 32'(dep[3]), 32'h1);
    tick();
    idle(); dst[15 +: 5] = 5'd9; dv[3] = 1'b1;
    smp(); check("waw_miss", 32'(dep[3]), 32'h0); tick();
    idle(); dst[15 +: 5] = 5'd4; dv[3] = 1'b1;
    smp(); check("waw_hit", 32'(dep[3]), 32'h1); tick();

    // RAW on warp 0 via src2, then WB clear
    idle(); alloc(0, 5'd5, 1'b1, 1'b0);
    smp(); check("w0_scbid0", 32'(scbid[1:0]), 32'h0); tick();
    idle(); src2[0 +: 5] = 5'd5; s2v[0] = 1'b1;
    smp(); check("raw_src2", 32'(dep[0]), 32'h1); tick();
    idle(); src2[0 +: 5] = 5'd5;
    smp(); check("raw_src2_off", 32'(dep[0]), 32'h0); tick();
    idle(); src2[0 +: 5] = 5'd5; s2v[0] = 1'b1; wbclr(0, 2'd0);
    smp(); check("raw_no_bypass", 32'(dep[0]), 32'h1); tick();
    idle(); src2[0 +: 5] = 5'd5; s2v[0] = 1'b1;
    smp();
    check("raw_cleared", 32'(dep[0]), 32'h0);
    check("w0_empty", 32'(empty[0]), 32'h1);
    tick();

    // LW in entry 1: completion then clear, then both together
    idle(); alloc(0, 5'd9, 1'b1, 1'b0); tick();
    idle(); alloc(0, 5'd7, 1'b1, 1'b1);
    smp(); check("lw_scbid", 32'(scbid[1:0]), 32'h1); tick();
    idle(); rcomp(0, 2'd1, 1'b0); tick();
    idle(); src1[0 +: 5] = 5'd7; s1v[0] = 1'b1;
    smp();
    check("lw_still_dep", 32'(dep[0]), 32'h1);
    check("lw_still_valid", 32'(scbid[1:0]), 32'h2);
    tick();
    idle(); wbclr(0, 2'd1); tick();
    idle(); smp(); check("lw_freed", 32'(scbid[1:0]), 32'h1); tick();
    idle(); alloc(0, 5'd7, 1'b1, 1'b1); tick();
    idle(); wbclr(0, 2'd1); rcomp(0, 2'd1, 1'b0); tick();
    idle(); src1[0 +: 5] = 5'd7; s1v[0] = 1'b1;
    smp();
    check("lw_same_cycle", 32'(scbid[1:0]), 32'h1);
    check("lw_same_dep", 32'(dep[0]), 32'h0);
    tick();

    // SW in entry 2 of warp 2
    idle(); alloc(2, 5'd1, 1'b1, 1'b0); tick();
    idle(); alloc(2, 5'd2, 1'b1, 1'b0); tick();
    idle(); alloc(2, 5'd0, 1'b0, 1'b1);
    smp(); check("sw_scbid", 32'(scbid[5:4]), 32'h2); tick();
    idle(); wbclr(2, 2'd0); tick();
    idle(); wbclr(2, 2'd1); tick();
    idle();
    smp();
    check("sw_pending", 32'(empty[2]), 32'h0);
    check("sw_pend_id", 32'(scbid[5:4]), 32'h0);
    tick();
    idle(); rcomp(2, 2'd2, 1'b1); tick();
    idle(); smp(); check("sw_freed", 32'(empty[2]), 32'h1); tick();
    idle(); alloc(2, 5'd3, 1'b0, 1'b0); tick();
    idle(); smp(); check("noop_alloc", 32'(empty[2]), 32'h1); tick();

    // Allocate and clear in the same cycle on warp 1
    idle(); alloc(1, 5'd3, 1'b1, 1'b0); tick();
    idle(); alloc(1, 5'd4, 1'b1, 1'b0); wbclr(1, 2'd0); tick();
    idle();
    smp();
    check("w1_scbid", 32'(scbid[3:2]), 32'h0);
    check("w1_empty", 32'(empty[1]), 32'h0);
    tick();

    // Warp isolation
    idle(); alloc(4, 5'd6, 1'b1, 1'b0); alloc(5, 5'd6, 1'b1, 1'b0); tick();
    idle(); wbclr(5, 2'd0); tick();
    idle();
    smp();
    check("iso_w5", 32'(empty[5]), 32'h1);
    check("iso_w4", 32'(empty[4]), 32'h0);
    tick();

    // Fill every warp, then reset with a clear pending
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int w = 0; w < W; w++) if (!m_full(w)) alloc(w, 5'(10 + c), 1'b1, 1'b0);
      tick();
    end
    idle(); smp(); check("all_full", 32'(full), 32'hFF); tick();
    idle(); rst = 1'b1; wbclr(0, 2'd0); tick();
    rst = 1'b0; idle();
    smp();
    check("midrst_empty", 32'(empty), 32'hFF);
    check("midrst_full", 32'(full), 32'h0);
    check("midrst_scbid", 32'(scbid), 32'h0);
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
